// File: rtl/fetch_unit.sv
// fetch_unit: PC/IR fetch FSM; in: clk, rst_n, imem_ack/rdata, stall, jump/branch/zero; out: imem_req/addr, instr, opcode, instr_valid, pc, pc_plus4, fetch_err
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);
  typedef enum logic [1:0] {IDLE, FETCH, VALID, ERROR} state_t;
  localparam logic [7:0] MW = 8'(MAX_WAIT);
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, br_off, pc_next;
  logic [7:0] wait_q, wait_d;
  assign pc_plus4 = pc_q + 32'd4;
  assign br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  assign pc_next = jump ? {pc_plus4[31:28], ir_q[25:0], 2'b00} : (branch && zero) ? pc_plus4 + br_off : pc_plus4;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    wait_d = wait_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        wait_d = '0;
      end
      FETCH: begin
        if (imem_ack) begin
          ir_d = imem_rdata;
          state_d = VALID;
        end else if (wait_q == MW) state_d = ERROR;
        else wait_d = wait_q + 8'd1;
      end
      VALID: begin
        if (!stall) begin
          pc_d = pc_next;
          state_d = FETCH;
          wait_d = '0;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      ir_q <= '0;
      wait_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      wait_q <= wait_d;
    end
  end
  assign imem_req = state_q == FETCH;
  assign imem_addr = pc_q;
  assign pc = pc_q;
  assign instr = ir_q;
  assign opcode = ir_q[31:26];
  assign instr_valid = state_q == VALID;
  assign fetch_err = state_q == ERROR;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven directed check of fetch_unit with MAX_WAIT=3
module tb_fetch_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0, instr, pc, pc_plus4;
  logic imem_req, imem_ack = 1'b0, stall = 1'b0, jump = 1'b0, branch = 1'b0, zero = 1'b0;
  logic instr_valid, fetch_err;
  logic [5:0] opcode;
  int n_cmp = 0, n_bad = 0;
  fetch_unit #(.RESET_PC(32'h0), .MAX_WAIT(3)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .jump(jump),
    .branch(branch), .zero(zero), .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rn, ack;
    logic [31:0] rd;
    logic st, j, b, z;
    logic e_req;
    logic [31:0] e_addr;
    logic e_val, e_err;
    logic [31:0] e_ins;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t v(logic rn, logic ack, logic [31:0] rd, logic st, logic j, logic b, logic z,
                             logic e_req, logic [31:0] e_addr, logic e_val, logic e_err, logic [31:0] e_ins);
    vec_t r;
    r.rn = rn; r.ack = ack; r.rd = rd; r.st = st; r.j = j; r.b = b; r.z = z;
    r.e_req = e_req; r.e_addr = e_addr; r.e_val = e_val; r.e_err = e_err; r.e_ins = e_ins;
    return r;
  endfunction
  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
    end
  endtask
  initial begin
    logic [31:0] e_pc4;
    logic [5:0] e_op;
    // rn ack rd st j b z | req addr val err instr
    tbl.push_back(v(1,0,0,0,0,0,0, 0,32'h0,0,0,32'h0));
    tbl.push_back(v(1,1,32'h20080005,0,0,0,0, 1,32'h0,0,0,32'h0));
    tbl.push_back(v(1,0,0,0,0,0,0, 0,32'h0,1,0,32'h20080005));
    tbl.push_back(v(1,1,32'h20090003,0,0,0,0, 1,32'h4,0,0,32'h20080005));
    tbl.push_back(v(1,0,0,0,0,0,0, 0,32'h4,1,0,32'h20090003));
    tbl.push_back(v(1,1,32'h08000004,0,0,0,0, 1,32'h8,0,0,32'h20090003));
    tbl.push_back(v(1,0,0,0,1,0,0, 0,32'h8,1,0,32'h08000004));
    tbl.push_back(v(1,1,32'h1109FFFE,0,0,0,0, 1,32'h10,0,0,32'h08000004));
    tbl.push_back(v(1,0,0,0,0,1,0, 0,32'h10,1,0,32'h1109FFFE));
    tbl.push_back(v(1,1,32'h08000004,0,0,0,0, 1,32'h14,0,0,32'h1109FFFE));
    tbl.push_back(v(1,0,0,0,1,0,0, 0,32'h14,1,0,32'h08000004));
    tbl.push_back(v(1,1,32'h1109FFFE,0,0,0,0, 1,32'h10,0,0,32'h08000004));
    tbl.push_back(v(1,0,0,0,0,1,1, 0,32'h10,1,0,32'h1109FFFE));
    tbl.push_back(v(1,1,32'h08000008,0,0,0,0, 1,32'hC,0,0,32'h1109FFFE));
    tbl.push_back(v(1,0,0,0,1,0,0, 0,32'hC,1,0,32'h08000008));
    tbl.push_back(v(1,1,32'h08000040,0,0,0,0, 1,32'h20,0,0,32'h08000008));
    tbl.push_back(v(1,0,0,0,1,1,1, 0,32'h20,1,0,32'h08000040));
    tbl.push_back(v(1,0,0,0,0,0,0, 1,32'h100,0,0,32'h08000040));
    tbl.push_back(v(1,1,32'h20080005,0,0,0,0, 1,32'h100,0,0,32'h08000040));
    tbl.push_back(v(1,0,0,1,1,0,0, 0,32'h100,1,0,32'h20080005));
    tbl.push_back(v(1,0,0,1,0,1,1, 0,32'h100,1,0,32'h20080005));
    tbl.push_back(v(1,0,0,1,1,0,0, 0,32'h100,1,0,32'h20080005));
    tbl.push_back(v(1,1,32'hFFFFFFFF,1,0,0,0, 0,32'h100,1,0,32'h20080005));
    tbl.push_back(v(1,0,0,1,1,1,1, 0,32'h100,1,0,32'h20080005));
    tbl.push_back(v(1,0,0,0,0,0,0, 0,32'h100,1,0,32'h20080005));
    tbl.push_back(v(1,0,0,0,1,0,0, 1,32'h104,0,0,32'h20080005));
    tbl.push_back(v(1,0,0,0,0,1,1, 1,32'h104,0,0,32'h20080005));
    tbl.push_back(v(1,0,0,0,0,0,0, 1,32'h104,0,0,32'h20080005));
    tbl.push_back(v(1,1,32'h1000FFBD,0,0,0,0, 1,32'h104,0,0,32'h20080005));
    tbl.push_back(v(1,0,0,0,0,1,1, 0,32'h104,1,0,32'h1000FFBD));
    tbl.push_back(v(1,1,32'h20090003,0,0,0,0, 1,32'hFFFFFFFC,0,0,32'h1000FFBD));
    tbl.push_back(v(1,0,0,0,0,0,0, 0,32'hFFFFFFFC,1,0,32'h20090003));
    tbl.push_back(v(1,0,0,0,0,0,0, 1,32'h0,0,0,32'h20090003));
    tbl.push_back(v(1,0,0,0,0,0,0, 1,32'h0,0,0,32'h20090003));
    tbl.push_back(v(1,0,0,0,0,0,0, 1,32'h0,0,0,32'h20090003));
    tbl.push_back(v(1,0,0,0,0,0,0, 1,32'h0,0,0,32'h20090003));
    tbl.push_back(v(1,1,32'h12345678,0,1,1,1, 0,32'h0,0,1,32'h20090003));
    tbl.push_back(v(1,1,32'h12345678,0,0,0,0, 0,32'h0,0,1,32'h20090003));
    tbl.push_back(v(0,0,0,0,0,0,0, 0,32'h0,0,1,32'h20090003));
    tbl.push_back(v(1,0,0,0,0,0,0, 0,32'h0,0,0,32'h0));
    tbl.push_back(v(1,1,32'h20080005,0,0,0,0, 1,32'h0,0,0,32'h0));
    tbl.push_back(v(1,0,0,0,0,0,0, 0,32'h0,1,0,32'h20080005));
    tbl.push_back(v(1,0,0,0,0,0,0, 1,32'h4,0,0,32'h20080005));
    tbl.push_back(v(0,0,0,0,0,0,0, 1,32'h4,0,0,32'h20080005));
    tbl.push_back(v(1,0,0,0,0,0,0, 0,32'h0,0,0,32'h0));
    tbl.push_back(v(1,1,32'h20090003,0,0,0,0, 1,32'h0,0,0,32'h0));
    tbl.push_back(v(0,0,0,1,0,0,0, 0,32'h0,1,0,32'h20090003));
    tbl.push_back(v(1,0,0,0,0,0,0, 0,32'h0,0,0,32'h0));
    tbl.push_back(v(1,0,0,0,0,0,0, 1,32'h0,0,0,32'h0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", -1, 32'(imem_req), 32'h0);
    chk("rst_valid", -1, 32'(instr_valid), 32'h0);
    chk("rst_err", -1, 32'(fetch_err), 32'h0);
    chk("rst_pc", -1, pc, 32'h0);
    chk("rst_instr", -1, instr, 32'h0);
    for (int i = 0; i < tbl.size(); i++) begin
      if (i > 0) @(negedge clk);
      rst_n = tbl[i].rn; imem_ack = tbl[i].ack; imem_rdata = tbl[i].rd;
      stall = tbl[i].st; jump = tbl[i].j; branch = tbl[i].b; zero = tbl[i].z;
      e_pc4 = tbl[i].e_addr + 32'd4;
      e_op = tbl[i].e_ins[31:26];
      chk("imem_req", i, 32'(imem_req), 32'(tbl[i].e_req));
      chk("imem_addr", i, imem_addr, tbl[i].e_addr);
      chk("pc", i, pc, tbl[i].e_addr);
      chk("pc_plus4", i, pc_plus4, e_pc4);
      chk("instr_valid", i, 32'(instr_valid), 32'(tbl[i].e_val));
      chk("fetch_err", i, 32'(fetch_err), 32'(tbl[i].e_err));
      chk("instr", i, instr, tbl[i].e_ins);
      chk("opcode", i, 32'(opcode), 32'(e_op));
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 Parameter MAX_WAIT, default 15, range 1-255: maximum unacknowledged request cycles before error.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 imem_addr  output  32  byte address of the word being fetched.
REQ-006 imem_req  output  1  fetch request to instruction memory.
REQ-007 imem_ack  input  1  imem_rdata valid this cycle.
REQ-008 imem_rdata  input  32  instruction word from memory.
REQ-009 stall  input  1  downstream cannot consume the held instruction.
REQ-010 jump  input  1  jump control for the held instruction.
REQ-011 branch  input  1  branch control for the held instruction.
REQ-012 zero  input  1  ALU zero flag for the held instruction.
REQ-013 instr  output  32  held instruction register (IR).
REQ-014 opcode  output  6  instr[31:26], feeds the decoder.
REQ-015 instr_valid  output  1  IR holds an unconsumed instruction.
REQ-016 pc  output  32  address of the instruction in IR.
REQ-017 pc_plus4  output  32  pc + 4, modulo 2^32.
REQ-018 fetch_err  output  1  sticky fetch-timeout flag.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, VALID, ERROR.
REQ-020 IDLE: imem_req=0; next state FETCH unconditionally.
REQ-021 FETCH: imem_req=1, imem_addr=pc; wait_cnt cleared on entry, incremented per cycle with imem_ack=0.
REQ-022 FETCH with imem_ack=1: IR<=imem_rdata, next state VALID; zero-wait ack (same cycle as first req) accepted.
REQ-023 FETCH with imem_ack=0 and wait_cnt==MAX_WAIT: next state ERROR; ack on the (MAX_WAIT+1)th request cycle is still accepted.
REQ-024 VALID: instr_valid=1, imem_req=0; stall=1 holds IR, pc and state unchanged.
REQ-025 VALID with stall=0: instruction consumed this cycle; jump/branch/zero sampled this cycle only; next state FETCH.
REQ-026 Next pc on consume, priority order: jump -> {pc_plus4[31:28], instr[25:0], 2'b00}; branch&zero -> pc_plus4 + (sext(instr[15:0])<<2); else pc_plus4.
REQ-027 jump and branch&zero together: jump wins.
REQ-028 jump/branch/zero SHALL be ignored in IDLE, FETCH, ERROR and in VALID with stall=1.
REQ-029 imem_ack outside FETCH SHALL be ignored; IR unchanged.
REQ-030 Address arithmetic modulo 2^32: pc 32'hFFFF_FFFC not taken -> 32'h0000_0000.
REQ-031 ERROR: imem_req=0, instr_valid=0, fetch_err=1; exits only via reset.
REQ-032 instr_valid SHALL be 1 only in VALID; opcode always equals instr[31:26].
REQ-033 Minimum throughput: one instruction per 2 cycles (FETCH with ack, VALID with stall=0).

Reset
REQ-034 rst_n low at a rising edge: state<=IDLE, pc<=RESET_PC, IR<=0, wait_cnt<=0, fetch_err<=0.
REQ-035 Reset mid-fetch or mid-hold abandons the transaction; imem_req=0 the cycle after the reset edge.
REQ-036 First request issued the second cycle after rst_n returns high, at imem_addr=RESET_PC.

Verification
REQ-037 Sequential: zero-wait ack, words 0x20080005 and 0x20090003, stall=0 -> imem_addr 0x0 then 0x4; opcode 0x08 twice; instr_valid every second cycle.
REQ-038 Branch: IR=0x1109FFFE at pc 0x10, branch=1, zero=1, stall=0 -> next imem_addr 0x0C; zero=0 -> 0x14.
REQ-039 Jump priority: IR=0x08000040 at pc 0x20, jump=1, branch=1, zero=1 -> next imem_addr 0x100.
REQ-040 Stall: stall=1 for 5 cycles in VALID with jump toggling -> instr, pc, instr_valid=1 constant, no imem_req; release with jump=0 -> fetch at pc+4.
REQ-041 Timeout: MAX_WAIT=3, imem_ack held 0 -> exactly 4 request cycles, then fetch_err=1, imem_req=0; later ack ignored; reset clears fetch_err and restarts at RESET_PC.
REQ-042 Wrap and reset: pc=0xFFFFFFFC consumed with no branch/jump -> next imem_addr 0x0; rst_n low during a waiting FETCH -> imem_req=0 next cycle, pc=RESET_PC.
